// File: rtl/addr_sequencer.sv
// -----------------------------------------------------------------------------
// addr_sequencer
//
// Produces the 8-bit address and the one-cycle write enable for the 256x16 RAM
// stage from the raw Nexys3 buttons. Each button passes through a 2-FF
// synchronizer, then a counter debouncer, then a rising-edge detector. Up and
// down presses step the address. A BTNR press issues a write. An optional
// auto-scan mode steps the address on a fixed tick to sweep the display.
//
// Ports
//   clk      in   1       system clock (100 MHz)
//   reset    in   1       synchronous, active-high reset
//   btn_up   in   1       raw button, asynchronous; step address +1
//   btn_dn   in   1       raw button, asynchronous; step address -1
//   btn_wr   in   1       raw button BTNR, asynchronous; request a RAM write
//   auto_en  in   1       raw switch, asynchronous; 1 = auto-scan mode
//   addr     out  ADDR_W  registered RAM address
//   we       out  1       registered write enable, one-cycle pulse per press
// -----------------------------------------------------------------------------
module addr_sequencer #(
    parameter int ADDR_W          = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_DIV        = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_wr,
    input  logic              auto_en,
    output logic [ADDR_W-1:0] addr,
    output logic              we
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AD_W = $clog2(AUTO_DIV + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AD_W-1:0] AD_LAST = AD_W'(AUTO_DIV - 1);

    // Bit positions of the three buttons in the input-path vectors.
    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_WR = 2;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_t;

    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      level;      // debounced button levels
    logic [2:0]      level_q;    // previous debounced levels, for edge detect
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      press;      // one-cycle press pulses

    logic            auto_s1;
    logic            auto_s2;
    logic            auto_q;
    logic [AD_W-1:0] auto_cnt;
    logic            auto_tick;
    logic            auto_entry;

    step_t           step_due;
    step_t           pending;
    step_t           next_pending;
    step_t           step_apply;

    assign raw   = {btn_wr, btn_dn, btn_up};
    assign press = level & ~level_q;

    // -------------------------------------------------------------------------
    // Input path: synchronize, debounce, keep the previous level for the edge.
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values and the pipeline order does not depend on the order
    // of the statements.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            // NOTE: the debounce counters are a small register array, not a
            // RAM, so they are cleared explicitly. A press held across reset
            // then restarts its debounce from zero.
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Auto-scan. The switch is only synchronized. The divider runs only while
    // the mode is on, so every entry starts counting from zero.
    // -------------------------------------------------------------------------
    assign auto_tick  = auto_s2 && (auto_cnt == AD_LAST);
    assign auto_entry = auto_s2 && !auto_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_s1  <= 1'b0;
            auto_s2  <= 1'b0;
            auto_q   <= 1'b0;
            auto_cnt <= '0;
        end else begin
            auto_s1 <= auto_en;
            auto_s2 <= auto_s1;
            auto_q  <= auto_s2;
            if (!auto_s2 || auto_tick) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Step selection. In auto mode the manual buttons are ignored. Up and down
    // pressed together cancel out.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    // -------------------------------------------------------------------------
    always_comb begin
        step_due = STEP_NONE;
        if (auto_s2) begin
            if (auto_tick) begin
                step_due = STEP_UP;
            end
        end else if (press[B_UP] && !press[B_DN]) begin
            step_due = STEP_UP;
        end else if (press[B_DN] && !press[B_UP]) begin
            step_due = STEP_DN;
        end

        // A new step overwrites a held one. Entering auto mode discards a held
        // manual step.
        next_pending = pending;
        if (step_due != STEP_NONE) begin
            next_pending = step_due;
        end else if (auto_entry) begin
            next_pending = STEP_NONE;
        end
        step_apply = next_pending;
    end

    // -------------------------------------------------------------------------
    // Address and write enable. A step due in the same cycle as a write pulse
    // is held, so addr is stable for the cycle in which we is raised and the
    // cycle in which we is high. The held step lands as we falls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr    <= '0;
            we      <= 1'b0;
            pending <= STEP_NONE;
        end else begin
            we <= press[B_WR];
            if (press[B_WR]) begin
                pending <= next_pending;
            end else begin
                pending <= STEP_NONE;
                case (step_apply)
                    STEP_UP: addr <= addr + 1'b1;
                    STEP_DN: addr <= addr - 1'b1;
                    default: addr <= addr;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_addr_sequencer
//
// Directed bench for addr_sequencer with DEBOUNCE_CYCLES=4 and AUTO_DIV=8.
// Inputs are driven and outputs are sampled 1 ns after a rising edge.
// "Edge k" means the k-th rising edge after an input change.
// With these parameters, a press held from edge 1 gives a pulse after edge 6,
// and addr/we change at edge 7.
// -----------------------------------------------------------------------------
module tb_addr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_wr;
    logic       auto_en;
    logic [7:0] addr;
    logic       we;

    int passed = 0;
    int total  = 0;

    addr_sequencer #(
        .ADDR_W         (8),
        .DEBOUNCE_CYCLES(4),
        .AUTO_DIV       (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .btn_wr (btn_wr),
        .auto_en(auto_en),
        .addr   (addr),
        .we     (we)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold one button for 10 cycles, then release it for 10 cycles.
    task automatic press(input int which);
        case (which)
            0:       btn_up = 1'b1;
            1:       btn_dn = 1'b1;
            default: btn_wr = 1'b1;
        endcase
        tick(10);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        btn_wr = 1'b0;
        tick(10);
    endtask

    // Run n cycles. Count the cycles where addr != exp_addr and the cycles
    // where we is high.
    task automatic watch(input int n, input logic [7:0] exp_addr,
                         output int bad_addr, output int we_cnt);
        bad_addr = 0;
        we_cnt   = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (addr !== exp_addr) bad_addr++;
            if (we !== 1'b0) we_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; btn_wr = 1'b0; auto_en = 1'b0;
        tick(2);
        total++;
        if (addr !== 8'h00) $display("FAIL reset_addr got=%h exp=00", addr); else passed++;
        total++;
        if (we !== 1'b0) $display("FAIL reset_we got=%b exp=0", we); else passed++;
        reset = 1'b0;
        tick(3);
        total++;
        if (addr !== 8'h00 || we !== 1'b0)
            $display("FAIL post_reset_idle addr=%h we=%b exp 00/0", addr, we);
        else passed++;
    endtask

    task automatic test_single_step();
        int bad, wes;
        btn_up = 1'b1;
        tick(6);
        total++;
        if (addr !== 8'h00) $display("FAIL step_latency_early got=%h exp=00", addr); else passed++;
        tick(1);
        total++;
        if (addr !== 8'h01) $display("FAIL step_up got=%h exp=01", addr); else passed++;
        watch(13, 8'h01, bad, wes);
        btn_up = 1'b0;
        total++;
        if (bad != 0 || wes != 0)
            $display("FAIL step_hold bad_addr=%0d we_cycles=%0d exp 0/0", bad, wes);
        else passed++;
        watch(10, 8'h01, bad, wes);
        total++;
        if (bad != 0 || wes != 0)
            $display("FAIL step_release bad_addr=%0d we_cycles=%0d exp 0/0", bad, wes);
        else passed++;
    endtask

    task automatic test_glitch();
        int bad, wes;
        btn_up = 1'b1;
        tick(3);
        btn_up = 1'b0;
        watch(12, 8'h01, bad, wes);
        total++;
        if (bad != 0 || wes != 0)
            $display("FAIL glitch bad_addr=%0d we_cycles=%0d exp 0/0", bad, wes);
        else passed++;
    endtask

    task automatic test_wrap();
        press(1);
        total++;
        if (addr !== 8'h00) $display("FAIL dn_step got=%h exp=00", addr); else passed++;
        press(1);
        total++;
        if (addr !== 8'hFF) $display("FAIL dn_wrap got=%h exp=ff", addr); else passed++;
        press(0);
        total++;
        if (addr !== 8'h00) $display("FAIL up_wrap got=%h exp=00", addr); else passed++;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        tick(10);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        tick(10);
        total++;
        if (addr !== 8'h00) $display("FAIL up_dn_cancel got=%h exp=00", addr); else passed++;
    endtask

    task automatic test_write_collision();
        for (int i = 0; i < 16; i++) press(0);
        total++;
        if (addr !== 8'h10) $display("FAIL climb_to_10 got=%h exp=10", addr); else passed++;
        btn_wr = 1'b1;
        btn_up = 1'b1;
        tick(6);
        total++;
        if (we !== 1'b0 || addr !== 8'h10)
            $display("FAIL coll_pre we=%b addr=%h exp 0/10", we, addr);
        else passed++;
        tick(1);
        total++;
        if (we !== 1'b1 || addr !== 8'h10)
            $display("FAIL coll_we we=%b addr=%h exp 1/10", we, addr);
        else passed++;
        tick(1);
        total++;
        if (we !== 1'b0 || addr !== 8'h11)
            $display("FAIL coll_after we=%b addr=%h exp 0/11", we, addr);
        else passed++;
        btn_wr = 1'b0;
        btn_up = 1'b0;
        tick(12);
        total++;
        if (we !== 1'b0 || addr !== 8'h11)
            $display("FAIL coll_settle we=%b addr=%h exp 0/11", we, addr);
        else passed++;
    endtask

    task automatic test_auto();
        int bad, wes;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        press(1);
        press(1);
        total++;
        if (addr !== 8'hFE) $display("FAIL auto_setup got=%h exp=fe", addr); else passed++;
        auto_en = 1'b1;
        tick(9);
        total++;
        if (addr !== 8'hFE) $display("FAIL auto_e9 got=%h exp=fe", addr); else passed++;
        tick(1);
        total++;
        if (addr !== 8'hFF) $display("FAIL auto_e10 got=%h exp=ff", addr); else passed++;
        btn_dn = 1'b1;
        tick(7);
        total++;
        if (addr !== 8'hFF) $display("FAIL auto_e17 got=%h exp=ff", addr); else passed++;
        tick(1);
        total++;
        if (addr !== 8'h00) $display("FAIL auto_e18 got=%h exp=00", addr); else passed++;
        tick(8);
        total++;
        if (addr !== 8'h01) $display("FAIL auto_e26 got=%h exp=01", addr); else passed++;
        btn_dn  = 1'b0;
        auto_en = 1'b0;
        watch(20, 8'h01, bad, wes);
        total++;
        if (bad != 0 || wes != 0)
            $display("FAIL auto_exit_hold bad_addr=%0d we_cycles=%0d exp 0/0", bad, wes);
        else passed++;
        press(0);
        total++;
        if (addr !== 8'h02) $display("FAIL manual_after_auto got=%h exp=02", addr); else passed++;
    endtask

    task automatic test_reset_mid_press();
        int bad, wes;
        btn_wr = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        total++;
        if (addr !== 8'h00 || we !== 1'b0)
            $display("FAIL midpress_reset addr=%h we=%b exp 00/0", addr, we);
        else passed++;
        reset = 1'b0;
        watch(6, 8'h00, bad, wes);
        total++;
        if (bad != 0 || wes != 0)
            $display("FAIL midpress_debounce bad_addr=%0d we_cycles=%0d exp 0/0", bad, wes);
        else passed++;
        tick(1);
        total++;
        if (we !== 1'b1 || addr !== 8'h00)
            $display("FAIL midpress_we we=%b addr=%h exp 1/00", we, addr);
        else passed++;
        watch(10, 8'h00, bad, wes);
        btn_wr = 1'b0;
        total++;
        if (bad != 0 || wes != 0)
            $display("FAIL midpress_single bad_addr=%0d we_cycles=%0d exp 0/0", bad, wes);
        else passed++;
        watch(12, 8'h00, bad, wes);
        total++;
        if (bad != 0 || wes != 0)
            $display("FAIL midpress_release bad_addr=%0d we_cycles=%0d exp 0/0", bad, wes);
        else passed++;
    endtask

    initial begin
        #1;
        test_reset();
        test_single_step();
        test_glitch();
        test_wrap();
        test_write_collision();
        test_auto();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
